aes_iter_encrypt: RTL and testbench
===================================

// Module: aes_iter_encrypt
// PURPOSE
//  Iterative AES-128 encryption datapath, one round per clock. Consumes the flat 11-round-key bus
//  from the combinational key expander and a 128-bit plaintext via valid/ready handshake.
//  Returns the ciphertext via valid/ready handshake. It is the block downstream of key expansion.
// PARAMETERS
//  NR        10    number of rounds; only 10 (AES-128) is supported
//  RK_W      1408  round-key bus width = 128*(NR+1)
// PORTS
//  clk         in   1     clock; single clock domain
//  rst_n       in   1     reset, asynchronous assert, active-low
//  in_valid    in   1     plaintext/key valid
//  in_ready    out  1     block can accept; high only in IDLE
//  plaintext   in   128   FIPS-197 byte order, byte0 = [127:120], column-major state
//  round_key   in   1408  expander output; upstream key must stay stable while busy=1
//  out_valid   out  1     ciphertext valid
//  out_ready   in   1     downstream accepts ciphertext
//  ciphertext  out  128   result, registered, same byte order as plaintext
//  busy        out  1     high in RUN or DONE
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - FSM=IDLE, rnd=0, state reg=0, ciphertext=0, out_valid=0, busy=0, in_ready=1.
//   - Reset mid-operation aborts the block silently; no partial output is produced.
//  Round-key slicing:
//   - Word w[j] = round_key[32j+31:32j] for j=0..43.
//   - RK(i) = {w[4i], w[4i+1], w[4i+2], w[4i+3]}, so w[4i] lands in bits [127:96].
//   - This word swap is mandatory; RK(0) equals the cipher key.
//  FSM:
//   - IDLE: in_ready=1. On in_valid&&in_ready: state<=plaintext^RK(0), rnd<=1, go to RUN.
//   - RUN: each cycle state<=AddRoundKey(MixColumns(ShiftRows(SubBytes(state))),RK(rnd)),
//     rnd<=rnd+1.
//   - RUN, rnd==NR: MixColumns is bypassed. Go to DONE, rnd<=0.
//   - DONE: out_valid=1, ciphertext=state. On out_ready, go to IDLE on the next edge.
//  Timing:
//   - Latency: accept edge T. Rounds complete at edges T+1..T+10.
//   - out_valid rises after edge T+10.
//   - Peak throughput: 1 block per 12 cycles (accept, 10 rounds, DONE handshake).
//  Handshake rules:
//   - in_valid while busy is ignored; no queuing.
//   - out_valid and ciphertext hold stable until out_ready (backpressure indefinite).
//   - out_ready without out_valid has no effect.
//   - DONE with out_ready=1 in the same cycle as in_valid=1: not accepted that cycle.
//     Acceptance happens in the following IDLE cycle.
//  Arithmetic:
//   - MixColumns in GF(2^8), polynomial x^8+x^4+x^3+x+1.
//   - xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1B : 8'h00).
//  rnd counter:
//   - 4 bits, never exceeds NR.
//   - Illegal FSM encodings return to IDLE.
// STRUCTURE
//  Shared package aes_pkg:
//   - NR, RK_W, state-machine enum (IDLE/RUN/DONE), xtime function.
//   - rk_slice(bus,i) function implementing the word-swapped slicing above.
//   - Existing S-box table/function, shared with the key expander.
//  One sub-module aes_round_comb:
//   - Purely combinational.
//   - Ports: state_in[127:0], rk[127:0], last (bypasses MixColumns), state_out[127:0].
//   - Contains 16 S-box lookups.
//  Top holds the FSM, rnd counter, state register and output register.
// TESTING
//  Bench drives the key expander's output into round_key.
//  1) key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734
//     -> ct 3925841d02dc09fbdc118597196a0b32; out_valid exactly 10 edges after accept.
//  2) key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff
//     -> ct 69c4e0d86a7b0430d8cdb78070b4c55a.
//  3) key 0, pt 0 -> ct 66e94bd4ef8a2c3b884cfa59ca342b2e.
//  4) Backpressure: out_ready low 7 cycles after out_valid; pulse in_valid with a new pt.
//     -> ciphertext stable, in_ready=0, second pt not accepted until after DONE handshake.
//  5) Reset mid-run: rst_n low at rnd=5.
//     -> out_valid=0, in_ready=1, ciphertext=0 immediately.
//     -> After release, test 1 vector gives the correct ct.
//  6) Back-to-back: out_ready=1, in_valid=1 continuously, 4 random blocks vs reference model.
//     -> Accepts every 12 cycles, all ct match.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round count, round-key bus width, FSM states,
// GF(2^8) xtime, word-swapped round-key slicing and the forward S-box.
package aes_pkg;

   localparam int NR   = 10;
   localparam int RK_W = 128 * (NR + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TBL[(255 - int'(b)) * 8 +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
   endfunction

   // Word w[4i] sits at the low end of the 128-bit slice but must land in bits [127:96].
   function automatic logic [127:0] rk_slice(input logic [RK_W-1:0] bus, input logic [3:0] i);
      logic [127:0] blk;
      blk = bus[128 * int'(i) +: 128];
      return {blk[31:0], blk[63:32], blk[95:64], blk[127:96]};
   endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One combinational AES encryption round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round_comb
   import aes_pkg::*;
(
   input  logic [127:0] state_in,
   input  logic [127:0] rk,
   input  logic         last,
   output logic [127:0] state_out
);

   logic [7:0] sb [16];
   logic [7:0] sr [16];
   logic [7:0] mc [16];

   always_comb begin
      sb        = '{default: '0};
      sr        = '{default: '0};
      mc        = '{default: '0};
      state_out = '0;
      for (int unsigned k = 0; k < 16; k++) begin
         sb[k] = sbox(state_in[127 - 8*k -: 8]);
      end
      // Byte index is 4*column + row; row r rotates left by r columns.
      for (int unsigned c = 0; c < 4; c++) begin
         for (int unsigned r = 0; r < 4; r++) begin
            sr[4*c + r] = sb[4*((c + r) % 4) + r];
         end
      end
      for (int unsigned c = 0; c < 4; c++) begin
         mc[4*c + 0] = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
         mc[4*c + 1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
         mc[4*c + 2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
         mc[4*c + 3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
      end
      for (int unsigned k = 0; k < 16; k++) begin
         state_out[127 - 8*k -: 8] = (last ? sr[k] : mc[k]) ^ rk[127 - 8*k -: 8];
      end
   end

endmodule

// File: rtl/aes_iter_encrypt.sv
// Iterative AES-128 encryption core, one round per clock, valid/ready on both sides.
module aes_iter_encrypt #(
   parameter int NR   = 10,
   parameter int RK_W = 1408
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [127:0]    plaintext,
   input  logic [RK_W-1:0] round_key,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [127:0]    ciphertext,
   output logic            busy
);
   import aes_pkg::*;

   state_e       fsm;
   logic [3:0]   rnd;
   logic [127:0] state_q;
   logic [127:0] ct_q;
   logic [127:0] round_out;
   logic         last_round;

   assign last_round = (rnd == 4'(NR));

   aes_round_comb u_round (
      .state_in  (state_q),
      .rk        (rk_slice(round_key, rnd)),
      .last      (last_round),
      .state_out (round_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm     <= IDLE;
         rnd     <= '0;
         state_q <= '0;
         ct_q    <= '0;
      end else begin
         case (fsm)
            IDLE: begin
               if (in_valid) begin
                  state_q <= plaintext ^ rk_slice(round_key, 4'd0);
                  rnd     <= 4'd1;
                  fsm     <= RUN;
               end
            end
            RUN: begin
               state_q <= round_out;
               if (last_round) begin
                  rnd  <= '0;
                  ct_q <= round_out;
                  fsm  <= DONE;
               end else begin
                  rnd <= rnd + 4'd1;
               end
            end
            DONE: begin
               if (out_ready) fsm <= IDLE;
            end
            default: begin
               fsm <= IDLE;
               rnd <= '0;
            end
         endcase
      end
   end

   assign in_ready   = (fsm == IDLE);
   assign out_valid  = (fsm == DONE);
   assign busy       = (fsm == RUN) || (fsm == DONE);
   assign ciphertext = ct_q;

endmodule

// File: tb/tb_aes_iter_encrypt.sv
// Self-checking bench for aes_iter_encrypt against a byte-array AES-128 reference model.
module tb_aes_iter_encrypt;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [127:0]   plaintext;
   logic [1407:0]  round_key;
   logic           out_valid;
   logic           out_ready;
   logic [127:0]   ciphertext;
   logic           busy;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] sbox_t [256];

   localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT1  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT1  = 128'h3925841d02dc09fbdc118597196a0b32;

   always #5 clk = ~clk;

   aes_iter_encrypt #(.NR(10), .RK_W(1408)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .plaintext  (plaintext),
      .round_key  (round_key),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .ciphertext (ciphertext),
      .busy       (busy)
   );

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic       hi;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         hi = a[7];
         a  = {a[6:0], 1'b0};
         if (hi) a = a ^ 8'h1b;
         b = {1'b0, b[7:1]};
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] d;
      d = {b, b} << n;
      return d[15:8];
   endfunction

   // S-box from first principles: multiplicative inverse then the affine map.
   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         if (x != 0) begin
            inv = 8'h01;
            for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(x));
         end
         sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   // Key schedule, packed with word j at bits [32j+31:32j] as the expander delivers it.
   function automatic logic [1407:0] key_words(input logic [127:0] key);
      logic [31:0]   w [44];
      logic [31:0]   t;
      logic [7:0]    rc;
      logic [1407:0] bus;
      rc = 8'h01;
      for (int j = 0; j < 4; j++) w[j] = key[127 - 32*j -: 32];
      for (int j = 4; j < 44; j++) begin
         t = w[j-1];
         if (j % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
            t[31:24] = t[31:24] ^ rc;
            rc = gmul(rc, 8'h02);
         end
         w[j] = w[j-4] ^ t;
      end
      for (int j = 0; j < 44; j++) bus[32*j +: 32] = w[j];
      return bus;
   endfunction

   function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
      logic [1407:0] bus;
      logic [7:0]    s [16];
      logic [7:0]    t [16];
      logic [7:0]    a0, a1, a2, a3;
      logic [127:0]  ct;
      bus = key_words(key);
      for (int k = 0; k < 16; k++) s[k] = pt[127 - 8*k -: 8];
      for (int rd = 0; rd <= 10; rd++) begin
         if (rd > 0) begin
            for (int k = 0; k < 16; k++) t[k] = sbox_t[s[k]];
            for (int c = 0; c < 4; c++)
               for (int r = 0; r < 4; r++) s[r + 4*c] = t[r + 4*((c + r) % 4)];
            if (rd < 10) begin
               for (int c = 0; c < 4; c++) begin
                  a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                  s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                  s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                  s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                  s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
               end
            end
         end
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               s[4*c + r] = s[4*c + r] ^ bus[32*(4*rd + c) + 31 - 8*r -: 8];
      end
      for (int k = 0; k < 16; k++) ct[127 - 8*k -: 8] = s[k];
      return ct;
   endfunction

   // Offers one block, waits for acceptance, then counts edges until out_valid (-1 on timeout).
   task automatic launch(input logic [127:0] key, input logic [127:0] pt, output int lat);
      int guard = 0;
      round_key = key_words(key);
      plaintext = pt;
      in_valid  = 1'b1;
      while (in_ready !== 1'b1 && guard < 40) begin
         @(posedge clk); #1;
         guard++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (out_valid !== 1'b1 && lat < 40);
      if (out_valid !== 1'b1 || guard >= 40) lat = -1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      plaintext = '0; round_key = '0;
      #3;
      vectors++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
         miscompares++;
         $display("FAIL reset_flags: got in_ready/out_valid/busy=%b required 100", {in_ready, out_valid, busy});
      end
      vectors++;
      if (ciphertext !== 128'h0) begin
         miscompares++;
         $display("FAIL reset_ct: got %h required 0", ciphertext);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_kat(input string name, input logic [127:0] key, input logic [127:0] pt,
                           input logic [127:0] exp);
      int lat;
      launch(key, pt, lat);
      vectors++;
      if (lat !== 10) begin
         miscompares++;
         $display("FAIL %s_latency: got %0d edges required 10", name, lat);
      end
      vectors++;
      if (ciphertext !== exp) begin
         miscompares++;
         $display("FAIL %s_ct: got %h required %h", name, ciphertext, exp);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      vectors++;
      if ({out_valid, in_ready, busy} !== 3'b010) begin
         miscompares++;
         $display("FAIL %s_release: got out_valid/in_ready/busy=%b required 010", name, {out_valid, in_ready, busy});
      end
   endtask

   task automatic test_backpressure();
      int          lat;
      logic [127:0] pt2;
      pt2 = {$urandom, $urandom, $urandom, $urandom};
      launch(KEY1, PT1, lat);
      for (int i = 0; i < 7; i++) begin
         in_valid  = (i == 2);
         plaintext = pt2;
         vectors++;
         if ({out_valid, in_ready, ciphertext} !== {1'b1, 1'b0, CT1}) begin
            miscompares++;
            $display("FAIL bp_hold_%0d: got ov=%b ir=%b ct=%h required ov=1 ir=0 ct=%h",
                     i, out_valid, in_ready, ciphertext, CT1);
         end
         @(posedge clk); #1;
      end
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      vectors++;
      if ({busy, in_ready} !== 2'b01) begin
         miscompares++;
         $display("FAIL bp_no_accept_in_done: got busy/in_ready=%b required 01", {busy, in_ready});
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL bp_accept_next_idle: got busy=%b required 1", busy);
      end
      lat = 0;
      while (out_valid !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      vectors++;
      if (ciphertext !== aes_ref(KEY1, pt2) || out_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL bp_second_ct: got ov=%b ct=%h required ov=1 ct=%h", out_valid, ciphertext, aes_ref(KEY1, pt2));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      round_key = key_words(KEY1);
      plaintext = PT1;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({out_valid, in_ready, busy, ciphertext} !== {3'b010, 128'h0}) begin
         miscompares++;
         $display("FAIL midrun_reset: got ov=%b ir=%b busy=%b ct=%h required ov=0 ir=1 busy=0 ct=0",
                  out_valid, in_ready, busy, ciphertext);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      test_kat("after_reset", KEY1, PT1, CT1);
   endtask

   task automatic test_back_to_back();
      logic [127:0] key;
      logic [127:0] pts [4];
      logic [127:0] exp [4];
      int           acc_cyc [$];
      int           sent = 0;
      int           got = 0;
      logic         acc;
      key = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < 4; i++) begin
         pts[i] = {$urandom, $urandom, $urandom, $urandom};
         exp[i] = aes_ref(key, pts[i]);
      end
      round_key = key_words(key);
      plaintext = pts[0];
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 200 && got < 4; cyc++) begin
         acc = in_valid && in_ready;
         if (out_valid === 1'b1) begin
            vectors++;
            if (ciphertext !== exp[got]) begin
               miscompares++;
               $display("FAIL b2b_ct_%0d: got %h required %h", got, ciphertext, exp[got]);
            end
            got++;
         end
         @(posedge clk); #1;
         if (acc) begin
            acc_cyc.push_back(cyc);
            sent++;
            if (sent < 4) plaintext = pts[sent];
            else in_valid = 1'b0;
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      vectors++;
      if (got != 4 || acc_cyc.size() != 4) begin
         miscompares++;
         $display("FAIL b2b_count: got %0d results %0d accepts required 4 and 4", got, acc_cyc.size());
      end
      for (int i = 1; i < acc_cyc.size(); i++) begin
         vectors++;
         if (acc_cyc[i] - acc_cyc[i-1] != 12) begin
            miscompares++;
            $display("FAIL b2b_interval_%0d: got %0d cycles required 12", i, acc_cyc[i] - acc_cyc[i-1]);
         end
      end
   endtask

   initial begin
      build_sbox();
      test_reset();
      test_kat("fips_c1", KEY1, PT1, CT1);
      test_kat("fips_c2", 128'h000102030405060708090a0b0c0d0e0f,
               128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      test_kat("zero", 128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
      test_backpressure();
      test_reset_mid_run();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
